piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in serial-out transmitter: the sending end of the team's SIPO shift-register link.
//  Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clk.
//  serial_out feeds a SIPO receiver's serial_in directly.
//  After WIDTH shifts, the receiver's shift register holds the transmitted word.
//  Gapless back-to-back words are supported.
// PARAMETERS
//  WIDTH  4  word length in bits; must be >= 2; bit counter is $clog2(WIDTH) bits wide
// PORTS
//  clk           in   1      single clock, all logic on posedge
//  rst_n         in   1      synchronous reset, active low
//  load_valid    in   1      parallel_in holds a word to send
//  load_ready    out  1      block can accept a word this cycle
//  parallel_in   in   WIDTH  word to serialize; sampled only on an accept
//  serial_out    out  1      serial data, MSB first
//  serial_valid  out  1      serial_out carries a data bit this cycle
//  done          out  1      high in the cycle serial_out carries bit 0 (last bit of the word)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - state=IDLE, shift_reg=0, bit_cnt=0.
//   - Resulting outputs: serial_out=0, serial_valid=0, done=0, load_ready=1.
//   - rst_n is sampled only at posedge; there is no asynchronous path.
//  Accept: load_valid && load_ready at a posedge.
//  States
//   - IDLE:
//     - load_ready=1, serial_valid=0, serial_out=0.
//     - On accept: shift_reg<=parallel_in, bit_cnt<=WIDTH-1, go to SHIFT.
//   - SHIFT:
//     - serial_out=shift_reg[WIDTH-1], serial_valid=1.
//     - Each posedge: shift_reg<={shift_reg[WIDTH-2:0],1'b0}, bit_cnt<=bit_cnt-1.
//     - When bit_cnt==0: done=1 and load_ready=1.
//     - At that edge, an accept reloads shift_reg and bit_cnt (stays in SHIFT).
//     - At that edge with no accept: go to IDLE.
//     - While bit_cnt!=0: load_ready=0.
//  Latency and timing
//   - Word accepted at edge k: bit WIDTH-1 is on serial_out in cycle k+1.
//   - Bit 0 is on serial_out in cycle k+WIDTH.
//   - Word occupies exactly WIDTH serial_valid cycles.
//   - serial_out, serial_valid and done are decoded from registered state only; no input-to-output combinational path.
//   - load_ready depends only on state and bit_cnt; it never depends on load_valid.
//  Boundaries
//   - load_valid while load_ready=0: ignored. parallel_in is not sampled, the frame in flight is unchanged, and the word is not queued.
//   - Back-to-back: an accept on the done cycle gives zero idle cycles between words; serial_valid stays high throughout.
//   - bit_cnt never wraps: it is reloaded or the FSM leaves SHIFT when it reaches 0.
//   - Reset mid-frame: the frame is dropped. Outputs take reset values after that edge, and no partial done is issued.
//   - Reset and accept at the same edge: reset wins; the word is not captured.
//   - parallel_in may change freely when no accept occurs.
// TESTING
//  1. Reset: hold rst_n=0 for 2 cycles with load_valid=1 -> serial_out=0, serial_valid=0, done=0, load_ready=1; nothing captured.
//  2. Single word, WIDTH=4, load 4'b1011 ->
//     - serial_out = 1,0,1,1 in cycles k+1..k+4; serial_valid high exactly those 4 cycles.
//     - done only in k+4; load_ready=0 in k+1..k+3.
//  3. Back-to-back: 4'hA then 4'h5 with load_valid held high -> 8 contiguous bits 1,0,1,0,0,1,0,1; serial_valid never drops; done in cycles 4 and 8.
//  4. Busy ignore: while sending 4'h3, assert load_valid with 4'hF at the second bit -> output stays 0,0,1,1; 4'hF is never sent.
//  5. Mid-frame reset: load 4'h9, pull rst_n low during bit 2 ->
//     - Next cycle serial_valid=0 and done never pulses.
//     - A later load of 4'h6 serializes cleanly as 0,1,1,0.
//  6. Loopback: serial_out feeds a SIPO receiver (WIDTH=4), 100 random words, random load_valid gaps -> receiver shift register equals each sent word on the cycle after its done.

Source files
------------

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Load handshake and serial output bundle for piso_serializer.
//                slave  = serializer side (accepts words, drives serial line)
//                master = word producer / serial consumer side
//  Signals     : load_valid   producer has a word on parallel_in
//                load_ready   serializer can accept a word this cycle
//                parallel_in  WIDTH-bit word to send
//                serial_out   serial data, MSB first
//                serial_valid serial_out carries a data bit
//                done         serial_out carries the last bit (bit 0)
//  Revision    : 1.0  initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] parallel_in;
    logic             serial_out;
    logic             serial_valid;
    logic             done;

    modport slave (
        input  load_valid,
        input  parallel_in,
        output load_ready,
        output serial_out,
        output serial_valid,
        output done
    );

    modport master (
        output load_valid,
        output parallel_in,
        input  load_ready,
        input  serial_out,
        input  serial_valid,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out transmitter. Accepts a WIDTH-bit word
//                on a valid/ready handshake and shifts it out MSB first, one
//                bit per clock. A word accepted on the last-bit cycle follows
//                with no gap. WIDTH must be >= 2.
//  Ports       : clk    clock, all logic on posedge
//                rst_n  synchronous reset, active low
//                bus    piso_serializer_if.slave (load handshake + serial out)
//  Revision    : 1.0  initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  wire                     clk,
    input  wire                     rst_n,
    piso_serializer_if.slave        bus
);

    localparam int                  c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;

    logic w_last_bit;
    logic w_load_ready;
    logic w_accept;
    logic w_serial_out;
    logic w_serial_valid;
    logic w_done;

    // Last bit of the frame is on the line: the only SHIFT cycle where a new
    // word may be taken, which is what makes back-to-back frames gapless.
    assign w_last_bit = (r_state == c_ST_SHIFT) && (r_bit_cnt == '0);
    assign w_accept   = bus.load_valid && w_load_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_last_bit && !w_accept) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: purely from registered state, so nothing on the serial
    // side or load_ready has a path from load_valid or parallel_in.
    // ------------------------------------------------------------------
    always_comb begin
        w_load_ready   = 1'b1;
        w_serial_out   = 1'b0;
        w_serial_valid = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_load_ready = 1'b1;
            end
            c_ST_SHIFT: begin
                w_serial_out   = r_shift[WIDTH-1];
                w_serial_valid = 1'b1;
                w_done         = w_last_bit;
                w_load_ready   = w_last_bit;
            end
            default: begin
                w_load_ready = 1'b1;
            end
        endcase
    end

    assign bus.load_ready   = w_load_ready;
    assign bus.serial_out   = w_serial_out;
    assign bus.serial_valid = w_serial_valid;
    assign bus.done         = w_done;

    // ------------------------------------------------------------------
    // Datapath: shift register and bit counter.
    // The counter holds at zero when the frame ends without a reload, so it
    // never wraps; the shift register has shifted out to all zeros by then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shift   <= bus.parallel_in;
            r_bit_cnt <= c_CNT_LAST;
        end else if (r_state == c_ST_SHIFT) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            if (r_bit_cnt != '0) begin
                r_bit_cnt <= r_bit_cnt - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire
